// File: rtl/bcd_sync_updn_cntr.sv
// ---------------------------------------------------------------------------
// bcd_sync_updn_cntr
//
// Synchronous multi-digit BCD up/down counter. It has a parallel load, a
// count enable, a combinational terminal-count lookahead and a registered
// wrap pulse. Every digit updates on the same clock edge, so nothing ripples
// and no internal clear can glitch. Two instances can be cascaded by driving
// the upper counter's en from the lower counter's tc.
//
// Parameters
//   DIGITS    number of BCD decades (1..8); the count is 4*DIGITS bits wide
//
// Ports
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset (count, wrap and load_err clear)
//   en        count enable, one step per clock while high
//   up        direction: 1 = increment, 0 = decrement
//   load      synchronous parallel-load strobe (has priority over en)
//   din       load value; digit k is din[4k+3:4k], digit 0 is least significant
//   count     registered BCD count
//   tc        terminal count: en & (up ? all nines : all zeros)
//   wrap      one-cycle pulse: the previous edge wrapped the count
//   load_err  one-cycle pulse: the previous load held an illegal digit
// ---------------------------------------------------------------------------

// Next-value logic for a single decade. inc and dec are mutually exclusive
// because the parent derives them from opposite values of up.
module bcd_digit (
    input  logic [3:0] cur,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] nxt,
    output logic       is_nine,
    output logic       is_zero
);

    assign is_nine = (cur == 4'd9);
    assign is_zero = (cur == 4'd0);

    always_comb begin
        nxt = cur;
        if (inc) begin
            nxt = is_nine ? 4'd0 : cur + 4'd1;
        end else if (dec) begin
            nxt = is_zero ? 4'd9 : cur - 4'd1;
        end
    end

endmodule

module bcd_sync_updn_cntr #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] din,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    // low_nines[k] is high when every digit below k holds 9; this is the
    // carry into digit k. low_zeros[k] is the matching borrow chain. Index
    // DIGITS covers the whole count and feeds the terminal count.
    logic [DIGITS:0]   low_nines;
    logic [DIGITS:0]   low_zeros;
    logic [DIGITS-1:0] digit_nine;
    logic [DIGITS-1:0] digit_zero;
    logic [DIGITS-1:0] digit_ok;
    logic [W-1:0]      count_next;
    logic              din_ok;

    assign low_nines[0] = 1'b1;
    assign low_zeros[0] = 1'b1;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            bcd_digit u_digit (
                .cur     (count[4*k +: 4]),
                .inc     (en & up & low_nines[k]),
                .dec     (en & ~up & low_zeros[k]),
                .nxt     (count_next[4*k +: 4]),
                .is_nine (digit_nine[k]),
                .is_zero (digit_zero[k])
            );

            assign low_nines[k+1] = low_nines[k] & digit_nine[k];
            assign low_zeros[k+1] = low_zeros[k] & digit_zero[k];
            assign digit_ok[k]    = (din[4*k +: 4] <= 4'd9);
        end
    endgenerate

    // One illegal digit rejects the whole load word.
    assign din_ok = &digit_ok;

    assign tc = en & (up ? low_nines[DIGITS] : low_zeros[DIGITS]);

    // The wrap and load_err pulses default low every cycle, so each one lasts
    // exactly one clock. A rejected load still takes priority over en. The
    // count therefore holds, and no step or wrap can happen in that cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (din_ok) begin
                    count <= din;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                count <= count_next;
                wrap  <= tc;
            end
        end
    end

endmodule

// File: tb/tb_bcd_sync_updn_cntr.sv
// ---------------------------------------------------------------------------
// tb_bcd_sync_updn_cntr
//
// Self-checking bench for bcd_sync_updn_cntr. The main DUT is a 4-digit
// counter. A directed vector table checks it first. Hand sequences then
// cover asynchronous reset, after which random stimulus is compared with a
// decimal reference model. The last part is a cascade of two 2-digit
// instances, which is compared with the same kind of model.
// ---------------------------------------------------------------------------
module tb_bcd_sync_updn_cntr;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] count;
    logic        tc;
    logic        wrap;
    logic        load_err;

    // cascade pair: lo is the low two digits, hi is the high two digits
    logic        c_en = 1'b0;
    logic        c_up = 1'b0;
    logic        c_load = 1'b0;
    logic [15:0] c_din = '0;
    logic [7:0]  lo_count;
    logic [7:0]  hi_count;
    logic        lo_tc;
    logic        hi_tc;
    logic        lo_wrap;
    logic        hi_wrap;
    logic        lo_err;
    logic        hi_err;

    int total = 0;
    int bad = 0;

    // reference model state: the count as a plain decimal number
    int m_val;
    logic m_wrap;
    logic m_err;
    int c_val;

    always #5 clk = ~clk;

    bcd_sync_updn_cntr #(.DIGITS(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .up       (up),
        .load     (load),
        .din      (din),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .load_err (load_err)
    );

    bcd_sync_updn_cntr #(.DIGITS(2)) u_lo (
        .clk      (clk),
        .rstn     (rstn),
        .en       (c_en),
        .up       (c_up),
        .load     (c_load),
        .din      (c_din[7:0]),
        .count    (lo_count),
        .tc       (lo_tc),
        .wrap     (lo_wrap),
        .load_err (lo_err)
    );

    bcd_sync_updn_cntr #(.DIGITS(2)) u_hi (
        .clk      (clk),
        .rstn     (rstn),
        .en       (lo_tc),
        .up       (c_up),
        .load     (c_load),
        .din      (c_din[15:8]),
        .count    (hi_count),
        .tc       (hi_tc),
        .wrap     (hi_wrap),
        .load_err (hi_err)
    );

    typedef struct {
        logic        ld;
        logic [15:0] d;
        logic        e;
        logic        u;
        logic        exp_tc;
        logic [15:0] exp_count;
        logic        exp_wrap;
        logic        exp_err;
    } vec_t;

    vec_t vecs[19];

    function automatic int bcd_to_int(input logic [15:0] b);
        int v = 0;
        for (int i = 3; i >= 0; i--) begin
            v = v * 10 + int'(b[4*i +: 4]);
        end
        return v;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int v);
        logic [15:0] b = '0;
        int r = v;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    function automatic logic bcd_legal(input logic [15:0] b);
        logic ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic model_tc(input int v, input logic e, input logic u);
        return e && (u ? (v == 9999) : (v == 0));
    endfunction

    // One clock edge of the counter, described in decimal arithmetic.
    task automatic model_step(input logic ld, input logic [15:0] d,
                              input logic e, input logic u);
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (ld) begin
            if (bcd_legal(d)) m_val = bcd_to_int(d);
            else              m_err = 1'b1;
        end else if (e) begin
            if (u) begin
                m_wrap = (m_val == 9999);
                m_val  = (m_val + 1) % 10000;
            end else begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + 9999) % 10000;
            end
        end
    endtask

    task automatic check_value(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive the main DUT's inputs just after a falling edge.
    task automatic apply_stimulus(input logic ld, input logic [15:0] d,
                                  input logic e, input logic u);
        @(negedge clk);
        load = ld;
        din  = d;
        en   = e;
        up   = u;
    endtask

    // Wait for the rising edge, then sample the registered outputs 1 ns later.
    task automatic check_output(input string tag, input logic [15:0] exp_count,
                                input logic exp_wrap, input logic exp_err);
        @(posedge clk);
        #1;
        check_value({tag, " count"}, 32'(count), 32'(exp_count));
        check_value({tag, " wrap"}, 32'(wrap), 32'(exp_wrap));
        check_value({tag, " load_err"}, 32'(load_err), 32'(exp_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        load = 1'b0; en = 1'b0; up = 1'b0; din = '0;
        c_load = 1'b0; c_en = 1'b0; c_up = 1'b0; c_din = '0;
        @(negedge clk);
        rstn = 1'b1;
        m_val = 0;
        c_val = 0;
    endtask

    initial begin
        logic [31:0] r;
        logic        ld, e, u;
        logic [15:0] d;
        logic        exp_tc;

        vecs[0]  = '{1'b1, 16'h0999, 1'b1, 1'b1, 1'b0, 16'h0999, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 16'h9998, 1'b0, 1'b1, 1'b0, 16'h9998, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0999, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 16'h0042, 1'b0, 1'b0, 1'b0, 16'h0042, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 16'h12A4, 1'b1, 1'b1, 1'b0, 16'h0042, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 16'h0005, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0};

        // reset state
        #12;
        check_value("reset count", 32'(count), 32'h0);
        check_value("reset wrap", 32'(wrap), 32'h0);
        check_value("reset load_err", 32'(load_err), 32'h0);
        do_reset();

        // directed vector table
        for (int i = 0; i < 19; i++) begin
            apply_stimulus(vecs[i].ld, vecs[i].d, vecs[i].e, vecs[i].u);
            #1;
            check_value($sformatf("vec%0d tc", i), 32'(tc), 32'(vecs[i].exp_tc));
            check_output($sformatf("vec%0d", i), vecs[i].exp_count,
                         vecs[i].exp_wrap, vecs[i].exp_err);
        end

        // reset while a wrap pulse is high cancels the pulse at once
        apply_stimulus(1'b1, 16'h9999, 1'b0, 1'b1);
        check_output("pre-wrap load", 16'h9999, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        check_output("pulse wrap", 16'h0000, 1'b1, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        check_value("rst cancels wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        en = 1'b0;
        check_output("no wrap after rst", 16'h0000, 1'b0, 1'b0);

        // reset while counting, asserted between clock edges
        apply_stimulus(1'b1, 16'h0457, 1'b0, 1'b1);
        check_output("load 0457", 16'h0457, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check_value("async rst count", 32'(count), 32'h0);
        check_value("async rst wrap", 32'(wrap), 32'h0);
        check_value("async rst load_err", 32'(load_err), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        check_output("first step after rst", 16'h0001, 1'b0, 1'b0);

        // random stimulus against the decimal model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom;
            ld = (r[2:0] == 3'd0);
            e  = (r[4:3] != 2'd0);
            u  = r[5];
            if (r[6]) begin
                d = int_to_bcd(int'($urandom_range(9999, 0)));
            end else begin
                r = $urandom;
                d = r[15:0];
            end
            apply_stimulus(ld, d, e, u);
            #1;
            exp_tc = model_tc(m_val, e, u);
            check_value("rand tc", 32'(tc), 32'(exp_tc));
            model_step(ld, d, e, u);
            check_output("rand", int_to_bcd(m_val), m_wrap, m_err);
        end

        // cascade corner cases: carry across the instance boundary, full wrap
        do_reset();
        @(negedge clk);
        c_load = 1'b1; c_din = 16'h0099;
        @(negedge clk);
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
        @(posedge clk);
        #1;
        check_value("casc 0099 up", 32'({hi_count, lo_count}), 32'h0100);
        check_value("casc lo wrap", 32'(lo_wrap), 32'h1);
        check_value("casc hi no wrap", 32'(hi_wrap), 32'h0);
        @(negedge clk);
        c_en = 1'b0; c_load = 1'b1; c_din = 16'h9999;
        @(negedge clk);
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
        #1;
        check_value("casc tc at 9999", 32'(hi_tc), 32'h1);
        @(posedge clk);
        #1;
        check_value("casc 9999 up", 32'({hi_count, lo_count}), 32'h0000);
        check_value("casc hi wrap", 32'(hi_wrap), 32'h1);

        // cascade random en/up against a single 4-digit decimal model
        c_val = 0;
        for (int i = 0; i < 20000; i++) begin
            r = $urandom;
            @(negedge clk);
            c_en = r[0] | r[1];
            c_up = r[2];
            #1;
            check_value("casc rand tc", 32'(hi_tc), 32'(model_tc(c_val, c_en, c_up)));
            exp_tc = model_tc(c_val, c_en, c_up);
            if (c_en) begin
                c_val = c_up ? (c_val + 1) % 10000 : (c_val + 9999) % 10000;
            end
            @(posedge clk);
            #1;
            check_value("casc rand count", 32'({hi_count, lo_count}), 32'(int_to_bcd(c_val)));
            check_value("casc rand wrap", 32'(hi_wrap), 32'(exp_tc));
        end
        check_value("casc lo err", 32'(lo_err), 32'h0);
        check_value("casc hi err", 32'(hi_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
